rng_nd: RTL and testbench
=========================

Name: rng_nd

Overview:
- N-dimensional range generator: produces nested index tuples (dim 0 innermost), each dim being base + i*incr, i = 0..last.
- Per-dimension eot flags on the output stream. Registered output stage gives full throughput.
- Optional skip port lets a consumer (e.g. early-reject in the cascade stage) abandon the remainder of a loop level.
- Sits between window/scale config sources and image-addressing consumers in the classifier datapath.

Parameters:
- NDIM, 2: number of nested dimensions, 1..4.
- W_START, 16: width of each dim's base field.
- W_CNT, 16: width of each dim's cnt field and step counter.
- W_INCR, 16: width of each dim's incr field.
- CNT_ONE_MORE, 0: 0 = dim emits cnt values (cnt==0 treated as 1); 1 = dim emits cnt+1 values.
- SIGNED, 0: 1 = base/incr sign-extended to W_VAL; 0 = zero-extended.
- Derived: W_VAL = max(W_START, W_INCR); W_CFG = W_INCR+W_CNT+W_START; W_SKIP = max(1, clog2(NDIM)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- cfg.data  in  NDIM*W_CFG  dim i at bits [i*W_CFG +: W_CFG], packed {incr, cnt, base} (base at LSB).
- cfg.valid  in  1.
- cfg.ready  out  1  one-cycle pulse when the transaction ends.
- skip.data  in  W_SKIP  loop level k to abandon.
- skip.valid  in  1.
- skip.ready  out  1  tied 1.
- dout.data  out  NDIM+NDIM*W_VAL  {eot[NDIM-1:0], val[NDIM-1], ..., val[0]}.
- dout.valid  out  1.
- dout.ready  in  1.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, dout.valid=0, dout.data=0, cfg.ready=0, all idx/val registers=0. A reset mid-transaction abandons it without consuming cfg.
- Generator holds a "pending" tuple: idx[i] (W_CNT) and val[i] (W_VAL) per dim.
- last[i] = (idx[i] == cnt[i]-1) when CNT_ONE_MORE=0 (cnt 0 counts as 1); last[i] = (idx[i] == cnt[i]) when CNT_ONE_MORE=1.
- FSM IDLE:
  - cfg.valid=1 -> load idx=0, val[i]=ext(base[i]), go RUN.
  - First element is on dout at the 2nd edge after cfg.valid is sampled.
- FSM RUN:
  - Output register is free when !dout.valid or dout.ready.
  - When free, load the pending tuple into the output register with eot[i] = AND of last[0..i].
  - Advance pending odometer-style: dim 0 increments; dim j increments only if dims 0..j-1 were all last; a wrapping dim resets to idx 0 / base.
  - Increment: val += ext(incr), modulo 2^W_VAL; idx += 1.
  - When the loaded tuple has eot[NDIM-1]=1: cfg.ready=1 that cycle, go IDLE.
- Throughput: one tuple per cycle while dout.ready=1. No bubble between transactions beyond the 1-cycle IDLE reload.
- dout.data stays stable while dout.valid=1 and dout.ready=0.
- cfg.data must remain stable from cfg.valid until cfg.ready; base/incr/cnt are read live.

Optional Feature:
- Macro: RNG_ND_SKIP_EN.
- Defined: skip.valid in RUN with level k (k<NDIM) acts on the pending tuple.
  - Dims 0..k reset to base; dim k+1 advances with normal carry.
  - If the carry leaves dim NDIM-1 (or k=NDIM-1), the transaction ends: cfg.ready=1, go IDLE, nothing further emitted. If dout.valid=1 and not accepted this cycle, its eot is forced to all ones; otherwise the transaction ends with no eot marker.
  - Skip has priority over a same-cycle output load: the load is suppressed that cycle.
  - skip.data >= NDIM is treated as NDIM-1. Skip in IDLE is ignored.
- Not defined: skip.ready=1, skip inputs ignored, no skip logic synthesised.

Test Plan:
- NDIM=2; dim0 {base0, cnt3, incr1}, dim1 {base10, cnt2, incr5}; dout.ready=1 -> (0,10),(1,10),(2,10)eot=01,(0,15),(1,15),(2,15)eot=11; cfg.ready pulses with the last tuple; 6 tuples in 6 consecutive cycles.
- Same cfg, dout.ready toggling 1010... -> identical sequence; data stable during stalls; cfg.ready only on the accepted-load cycle of (2,15).
- SIGNED=1, W_VAL=8, NDIM=1: base=-2, incr=-3, cnt=3 -> -2,-5,-8, eot on -8. CNT_ONE_MORE=1 with cnt=3 -> 4 values ending at -11.
- RNG_ND_SKIP_EN, first test's cfg: skip k=0 while pending=(1,10) -> next output (0,15). Skip k=1 while pending=(1,15) and dout.valid held -> held tuple's eot becomes 11, cfg.ready pulses, FSM IDLE.
- rst low for 1 cycle mid-run after (1,10) -> dout.valid=0 immediately, cfg.ready stays 0. Re-presented cfg restarts at (0,10).
- cnt=0, CNT_ONE_MORE=0, NDIM=1, base=7 -> single tuple 7 with eot=1, cfg.ready pulses.

Source files
------------

// File: rtl/rng_nd_if.sv
`default_nettype none
// ============================================================================
// Module  : rng_nd_if
// Brief   : Valid/ready stream bundle used by the rng_nd config, skip and output ports.
// Rev     : 1.0  initial release
// ============================================================================
interface rng_nd_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/rng_nd.sv
`default_nettype none
// ============================================================================
// Module  : rng_nd
// Brief   : N-dimensional nested range generator with per-dimension eot flags.
//           Optional loop-level skip port enabled by defining RNG_ND_SKIP_EN.
// Rev     : 1.0  initial release
// ============================================================================
module rng_nd #(
  parameter int NDIM         = 2,
  parameter int W_START      = 16,
  parameter int W_CNT        = 16,
  parameter int W_INCR       = 16,
  parameter int CNT_ONE_MORE = 0,
  parameter int SIGNED       = 0,
  localparam int W_VAL  = (W_START > W_INCR) ? W_START : W_INCR,
  localparam int W_CFG  = W_INCR + W_CNT + W_START,
  localparam int W_SKIP = (NDIM > 1) ? $clog2(NDIM) : 1,
  localparam int W_DOUT = NDIM + NDIM * W_VAL
) (
  input  wire logic clk,
  input  wire logic rst,
  rng_nd_if.slave   cfg,
  rng_nd_if.slave   skip,
  rng_nd_if.master  dout
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [W_CNT-1:0]   r_idx      [NDIM];
  logic [W_VAL-1:0]   r_val      [NDIM];
  logic [W_CNT-1:0]   w_idx_next [NDIM];
  logic [W_VAL-1:0]   w_val_next [NDIM];
  logic [W_VAL-1:0]   w_base     [NDIM];
  logic [W_VAL-1:0]   w_incr     [NDIM];
  logic [NDIM-1:0]    w_last;
  logic [NDIM-1:0]    w_eot;

  logic               r_dout_valid;
  logic [W_DOUT-1:0]  r_dout_data;
  logic               w_dout_valid_next;
  logic [W_DOUT-1:0]  w_dout_data_next;

  logic               w_cfg_ready;
  logic               w_load;
  logic               w_skip_req;
  logic               w_skip_act;
  logic               w_carry;
  int                 w_skip_lvl;

  for (genvar i = 0; i < NDIM; i++) begin : g_dim
    logic [W_START-1:0] w_base_f;
    logic [W_CNT-1:0]   w_cnt_f;
    logic [W_INCR-1:0]  w_incr_f;

    assign w_base_f = cfg.data[i*W_CFG +: W_START];
    assign w_cnt_f  = cfg.data[i*W_CFG + W_START +: W_CNT];
    assign w_incr_f = cfg.data[i*W_CFG + W_START + W_CNT +: W_INCR];

    if (SIGNED != 0) begin : g_sext
      assign w_base[i] = W_VAL'($signed(w_base_f));
      assign w_incr[i] = W_VAL'($signed(w_incr_f));
    end else begin : g_zext
      assign w_base[i] = W_VAL'(w_base_f);
      assign w_incr[i] = W_VAL'(w_incr_f);
    end

    // A zero count still produces one element when counts are exclusive.
    if (CNT_ONE_MORE != 0) begin : g_last_inc
      assign w_last[i] = (r_idx[i] == w_cnt_f);
    end else begin : g_last_exc
      assign w_last[i] = (w_cnt_f == '0) ? (r_idx[i] == '0)
                                         : (r_idx[i] == w_cnt_f - W_CNT'(1));
    end
  end

`ifdef RNG_ND_SKIP_EN
  assign w_skip_req = skip.valid;
  assign w_skip_lvl = (int'(skip.data) >= NDIM) ? NDIM - 1 : int'(skip.data);
`else
  logic w_unused_skip;
  assign w_unused_skip = ^{skip.data, skip.valid};
  assign w_skip_req    = 1'b0;
  assign w_skip_lvl    = 0;
`endif
  assign skip.ready = 1'b1;

  always_comb begin
    w_state_next      = r_state;
    w_cfg_ready       = 1'b0;
    w_load            = 1'b0;
    w_skip_act        = 1'b0;
    w_carry           = 1'b0;
    w_eot             = '0;
    w_idx_next        = r_idx;
    w_val_next        = r_val;
    w_dout_valid_next = r_dout_valid & ~dout.ready;
    w_dout_data_next  = r_dout_data;
    case (r_state)
      S_IDLE: begin
        if (cfg.valid) begin
          for (int j = 0; j < NDIM; j++) begin
            w_idx_next[j] = '0;
            w_val_next[j] = w_base[j];
          end
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_skip_act = w_skip_req;
        w_load     = (~r_dout_valid | dout.ready) & ~w_skip_req;
        // Odometer carry; a skip clears dims 0..k and injects the carry at k+1.
        w_carry    = ~w_skip_req;
        for (int j = 0; j < NDIM; j++) begin
          if (w_skip_act && (j <= w_skip_lvl)) begin
            w_idx_next[j] = '0;
            w_val_next[j] = w_base[j];
            w_carry       = (j == w_skip_lvl);
          end else if (w_carry) begin
            if (w_last[j]) begin
              w_idx_next[j] = '0;
              w_val_next[j] = w_base[j];
            end else begin
              w_idx_next[j] = r_idx[j] + W_CNT'(1);
              w_val_next[j] = r_val[j] + w_incr[j];
            end
            w_carry = w_last[j];
          end
          w_eot[j] = w_carry;
        end
        if (!(w_load || w_skip_act)) begin
          w_idx_next = r_idx;
          w_val_next = r_val;
        end
        if (w_load) begin
          for (int j = 0; j < NDIM; j++) begin
            w_dout_data_next[j*W_VAL +: W_VAL] = r_val[j];
          end
          w_dout_data_next[NDIM*W_VAL +: NDIM] = w_eot;
          w_dout_valid_next                    = 1'b1;
        end
        if (w_carry && (w_load || w_skip_act)) begin
          w_cfg_ready  = 1'b1;
          w_state_next = S_IDLE;
          // A tuple still waiting on the consumer becomes the closing one.
          if (w_skip_act && r_dout_valid && !dout.ready) begin
            w_dout_data_next[NDIM*W_VAL +: NDIM] = '1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout_valid <= 1'b0;
      r_dout_data  <= '0;
      for (int j = 0; j < NDIM; j++) begin
        r_idx[j] <= '0;
        r_val[j] <= '0;
      end
    end else begin
      r_dout_valid <= w_dout_valid_next;
      r_dout_data  <= w_dout_data_next;
      r_idx        <= w_idx_next;
      r_val        <= w_val_next;
    end
  end

  assign cfg.ready  = w_cfg_ready;
  assign dout.valid = r_dout_valid;
  assign dout.data  = r_dout_data;

endmodule
`default_nettype wire

// File: tb/tb_rng_nd.sv
`default_nettype none
// ============================================================================
// Module  : tb_rng_nd
// Brief   : Scoreboard bench for rng_nd (2-D unsigned, 1-D signed, 1-D inclusive count).
// Rev     : 1.0  initial release
// ============================================================================
module tb_rng_nd;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  rng_nd_if #(.W(96)) cfg_a ();
  rng_nd_if #(.W(1))  skip_a ();
  rng_nd_if #(.W(34)) dout_a ();
  rng_nd_if #(.W(24)) cfg_b ();
  rng_nd_if #(.W(1))  skip_b ();
  rng_nd_if #(.W(9))  dout_b ();
  rng_nd_if #(.W(24)) cfg_c ();
  rng_nd_if #(.W(1))  skip_c ();
  rng_nd_if #(.W(9))  dout_c ();

  rng_nd dut_a (.clk(clk), .rst(rst), .cfg(cfg_a), .skip(skip_a), .dout(dout_a));
  rng_nd #(.NDIM(1), .W_START(8), .W_CNT(8), .W_INCR(8), .CNT_ONE_MORE(0), .SIGNED(1))
    dut_b (.clk(clk), .rst(rst), .cfg(cfg_b), .skip(skip_b), .dout(dout_b));
  rng_nd #(.NDIM(1), .W_START(8), .W_CNT(8), .W_INCR(8), .CNT_ONE_MORE(1), .SIGNED(1))
    dut_c (.clk(clk), .rst(rst), .cfg(cfg_c), .skip(skip_c), .dout(dout_c));

  localparam logic [95:0] CFG1 = {16'd5, 16'd2, 16'd10, 16'd1, 16'd3, 16'd0};

  logic [33:0] exp_a [$];
  logic [8:0]  exp_b [$];
  logic [8:0]  exp_c [$];
  int          acc_cyc_a [$];
  int          npulse_a, npulse_b, npulse_c, pulse_cyc_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [33:0] mk_a(input logic [1:0] eot, input int v1, input int v0);
    return {eot, v1[15:0], v0[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor plus stall-stability and cfg.ready pulse tracking.
  initial begin
    logic        pv_a, pr_a, ps_a, pv_b, pr_b, pv_c, pr_c;
    logic [33:0] pd_a;
    logic [8:0]  pd_b, pd_c;
    pv_a = 0; pr_a = 0; ps_a = 0; pd_a = '0;
    pv_b = 0; pr_b = 0; pd_b = '0; pv_c = 0; pr_c = 0; pd_c = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (dout_a.valid && dout_a.ready) begin
          acc_cyc_a.push_back(cyc);
          if (exp_a.size() == 0) chk("a_unexpected", {30'd0, dout_a.data}, 64'h0);
          else chk("a_tuple", {30'd0, dout_a.data}, {30'd0, exp_a.pop_front()});
        end
        if (pv_a && !pr_a && !ps_a && dout_a.valid) chk("a_stall_stable", {30'd0, dout_a.data}, {30'd0, pd_a});
        if (dout_b.valid && dout_b.ready) begin
          if (exp_b.size() == 0) chk("b_unexpected", {55'd0, dout_b.data}, 64'h0);
          else chk("b_tuple", {55'd0, dout_b.data}, {55'd0, exp_b.pop_front()});
        end
        if (pv_b && !pr_b && dout_b.valid) chk("b_stall_stable", {55'd0, dout_b.data}, {55'd0, pd_b});
        if (dout_c.valid && dout_c.ready) begin
          if (exp_c.size() == 0) chk("c_unexpected", {55'd0, dout_c.data}, 64'h0);
          else chk("c_tuple", {55'd0, dout_c.data}, {55'd0, exp_c.pop_front()});
        end
        if (pv_c && !pr_c && dout_c.valid) chk("c_stall_stable", {55'd0, dout_c.data}, {55'd0, pd_c});
        pv_a = dout_a.valid; pr_a = dout_a.ready; ps_a = skip_a.valid; pd_a = dout_a.data;
        pv_b = dout_b.valid; pr_b = dout_b.ready; pd_b = dout_b.data;
        pv_c = dout_c.valid; pr_c = dout_c.ready; pd_c = dout_c.data;
      end else begin
        pv_a = 0; pv_b = 0; pv_c = 0;
      end
      if (cfg_a.ready === 1'b1) begin
        npulse_a++;
        pulse_cyc_a = cyc;
      end
      if (cfg_b.ready === 1'b1) npulse_b++;
      if (cfg_c.ready === 1'b1) npulse_c++;
    end
  end

  task automatic wait_cfg_a(input bit toggle, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (cfg_a.ready === 1'b1) seen = 1;
      tick();
      if (seen) cfg_a.valid = 1'b0;
      if (toggle) dout_a.ready = ~dout_a.ready;
    end
    chk("a_cfg_ready_seen", {63'd0, seen}, 64'd1);
  endtask

  task automatic wait_cfg_bc(input bit wb, input bit wc, input int budget);
    bit db, dc;
    db = !wb;
    dc = !wc;
    for (int i = 0; i < budget && !(db && dc); i++) begin
      @(negedge clk);
      if (!db && cfg_b.ready === 1'b1) db = 1;
      if (!dc && cfg_c.ready === 1'b1) dc = 1;
      tick();
      if (db) cfg_b.valid = 1'b0;
      if (dc) cfg_c.valid = 1'b0;
    end
    chk("bc_cfg_ready_seen", {62'd0, db, dc}, 64'd3);
  endtask

  task automatic push_full_a();
    exp_a.push_back(mk_a(2'b00, 10, 0));
    exp_a.push_back(mk_a(2'b00, 10, 1));
    exp_a.push_back(mk_a(2'b01, 10, 2));
    exp_a.push_back(mk_a(2'b00, 15, 0));
    exp_a.push_back(mk_a(2'b00, 15, 1));
    exp_a.push_back(mk_a(2'b11, 15, 2));
  endtask

  initial begin
    int t0, a0, p0, pb0, pc0;
    checks = 0; failures = 0;
    npulse_a = 0; npulse_b = 0; npulse_c = 0; pulse_cyc_a = 0;
    rst = 1'b0;
    cfg_a.data = '0; cfg_a.valid = 0; skip_a.data = '0; skip_a.valid = 0; dout_a.ready = 1;
    cfg_b.data = '0; cfg_b.valid = 0; skip_b.data = '0; skip_b.valid = 0; dout_b.ready = 1;
    cfg_c.data = '0; cfg_c.valid = 0; skip_c.data = '0; skip_c.valid = 0; dout_c.ready = 1;
    repeat (3) tick();
    chk("reset_a_valid", {63'd0, dout_a.valid}, 64'd0);
    chk("reset_a_data", {30'd0, dout_a.data}, 64'd0);
    chk("reset_a_cfg_ready", {63'd0, cfg_a.ready}, 64'd0);
    chk("reset_b_valid", {63'd0, dout_b.valid}, 64'd0);
    rst = 1'b1;
    tick();

    // 2-D sweep at full throughput
    push_full_a();
    p0 = npulse_a; a0 = acc_cyc_a.size();
    tick();
    cfg_a.data = CFG1; cfg_a.valid = 1;
    t0 = cyc;
    wait_cfg_a(0, 20);
    repeat (3) tick();
    chk("t1_first_latency", 64'(acc_cyc_a[a0]), 64'(t0 + 2));
    chk("t1_last_cycle", 64'(acc_cyc_a[a0 + 5]), 64'(t0 + 7));
    chk("t1_cfg_ready_cycle", 64'(pulse_cyc_a), 64'(t0 + 6));
    chk("t1_cfg_ready_count", 64'(npulse_a - p0), 64'd1);

    // same sweep with a 1010 consumer
    push_full_a();
    p0 = npulse_a;
    tick();
    cfg_a.data = CFG1; cfg_a.valid = 1;
    wait_cfg_a(1, 30);
    dout_a.ready = 1;
    repeat (4) tick();
    chk("t2_cfg_ready_count", 64'(npulse_a - p0), 64'd1);
    chk("t2_drained", 64'(exp_a.size()), 64'd0);

    // reset mid-run after (1,10), then restart
    exp_a.push_back(mk_a(2'b00, 10, 0));
    exp_a.push_back(mk_a(2'b00, 10, 1));
    a0 = acc_cyc_a.size();
    tick();
    cfg_a.data = CFG1; cfg_a.valid = 1;
    for (int i = 0; i < 20 && acc_cyc_a.size() != a0 + 2; i++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_reached_1_10", 64'(acc_cyc_a.size()), 64'(a0 + 2));
    rst = 1'b0;
    #1;
    chk("rst_dout_valid", {63'd0, dout_a.valid}, 64'd0);
    chk("rst_cfg_ready", {63'd0, cfg_a.ready}, 64'd0);
    chk("rst_queue_empty", 64'(exp_a.size()), 64'd0);
    p0 = npulse_a;
    push_full_a();
    @(negedge clk);
    #1;
    rst = 1'b1;
    wait_cfg_a(0, 20);
    repeat (3) tick();
    chk("rst_restart_pulses", 64'(npulse_a - p0), 64'd1);

    // signed 1-D: exclusive count on b, inclusive count on c
    exp_b.push_back({1'b0, 8'hFE}); exp_b.push_back({1'b0, 8'hFB}); exp_b.push_back({1'b1, 8'hF8});
    exp_c.push_back({1'b0, 8'hFE}); exp_c.push_back({1'b0, 8'hFB});
    exp_c.push_back({1'b0, 8'hF8}); exp_c.push_back({1'b1, 8'hF5});
    pb0 = npulse_b; pc0 = npulse_c;
    tick();
    cfg_b.data = 24'hFD03FE; cfg_b.valid = 1;
    cfg_c.data = 24'hFD03FE; cfg_c.valid = 1;
    wait_cfg_bc(1, 1, 20);
    repeat (3) tick();

    // cnt=0 yields a single closing element
    exp_b.push_back({1'b1, 8'h07});
    tick();
    cfg_b.data = 24'h010007; cfg_b.valid = 1;
    wait_cfg_bc(1, 0, 20);
    repeat (3) tick();
    chk("b_cfg_ready_count", 64'(npulse_b - pb0), 64'd2);
    chk("c_cfg_ready_count", 64'(npulse_c - pc0), 64'd1);

`ifdef RNG_ND_SKIP_EN
    // skip level 0 while pending=(1,10)
    exp_a.push_back(mk_a(2'b00, 10, 0));
    exp_a.push_back(mk_a(2'b00, 15, 0));
    exp_a.push_back(mk_a(2'b00, 15, 1));
    exp_a.push_back(mk_a(2'b11, 15, 2));
    tick();
    cfg_a.data = CFG1; cfg_a.valid = 1;
    tick(); tick();
    skip_a.data = 1'b0; skip_a.valid = 1;
    chk("skip_ready", {63'd0, skip_a.ready}, 64'd1);
    tick();
    skip_a.valid = 0;
    wait_cfg_a(0, 20);
    repeat (3) tick();

    // skip level 1 while (0,15) is held and pending=(1,15)
    exp_a.push_back(mk_a(2'b00, 10, 0));
    exp_a.push_back(mk_a(2'b00, 10, 1));
    exp_a.push_back(mk_a(2'b01, 10, 2));
    exp_a.push_back(mk_a(2'b11, 15, 0));
    p0 = npulse_a;
    tick();
    cfg_a.data = CFG1; cfg_a.valid = 1;
    repeat (5) tick();
    dout_a.ready = 0; skip_a.data = 1'b1; skip_a.valid = 1;
    @(negedge clk);
    chk("skip_end_cfg_ready", {63'd0, cfg_a.ready}, 64'd1);
    tick();
    skip_a.valid = 0; cfg_a.valid = 0;
    tick(); tick();
    chk("skip_held_valid", {63'd0, dout_a.valid}, 64'd1);
    chk("skip_held_eot", {62'd0, dout_a.data[33:32]}, 64'd3);
    dout_a.ready = 1;
    repeat (4) tick();
    chk("skip_end_pulses", 64'(npulse_a - p0), 64'd1);
`endif

    chk("final_a_empty", 64'(exp_a.size()), 64'd0);
    chk("final_b_empty", 64'(exp_b.size()), 64'd0);
    chk("final_c_empty", 64'(exp_c.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
